tt_sweep_ctrl: RTL and testbench

TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

---
 rtl/tt_sweep_pkg.sv | 17 +
 rtl/tt_sweep_ctrl.sv | 150 +++++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types for the truth-table sweep controller: FSM state encoding and
// the pattern-count derivation used to size the captured table.
package tt_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic int n_pts(input int n_in);
    return 32'sd1 << n_in;
  endfunction

endpackage

// File: rtl/tt_sweep_ctrl.sv
// Sweeps every input pattern of a combinational function, captures its truth
// table, then checks whether f(x) == f(x ^ alpha) holds for all x.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int N_IN   = 5,
  parameter int SETTLE = 1,
  localparam int N_PTS = n_pts(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_IN-1:0]  alpha,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  dut_x,
  input  logic             dut_y,
  output logic [N_PTS-1:0] tt,
  output logic             tt_valid,
  output logic             sym
);

  localparam logic [N_IN-1:0] LAST_IDX    = N_IN'(N_PTS - 1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

  state_t           state_r, state_s;
  logic [N_IN-1:0]  idx_r, idx_s;
  logic [N_IN-1:0]  chk_r, chk_s;
  logic [N_IN-1:0]  alpha_r, alpha_s;
  logic [N_IN-1:0]  dut_x_r, dut_x_s;
  logic [3:0]       settle_r, settle_s;
  logic [N_PTS-1:0] tt_r, tt_s;
  logic             sym_r, sym_s;
  logic             tt_valid_r, tt_valid_s;
  logic             done_r, done_s;
  logic             busy_r, busy_s;
  logic             mism_s;

  // Symmetry test for the current check index against its alpha partner
  always_comb begin
    mism_s = (tt_r[chk_r] != tt_r[chk_r ^ alpha_r]);
  end

  // Next-state and next-output computation for the sweep/check FSM
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    chk_s      = chk_r;
    alpha_s    = alpha_r;
    settle_s   = settle_r;
    tt_s       = tt_r;
    sym_s      = sym_r;
    tt_valid_s = tt_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          alpha_s    = alpha;
          tt_valid_s = 1'b0;
          idx_s      = {N_IN{1'b0}};
          settle_s   = 4'd0;
          state_s    = ST_DRIVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (settle_r == SETTLE_LAST) begin
          settle_s = 4'd0;
          state_s  = ST_SAMPLE;
        end else begin
          settle_s = settle_r + 4'd1;
        end
      end
      ST_SAMPLE: begin
        tt_s[idx_r] = dut_y;
        if (idx_r == LAST_IDX) begin
          chk_s   = {N_IN{1'b0}};
          state_s = ST_CHECK;
        end else begin
          idx_s   = idx_r + {{(N_IN-1){1'b0}}, 1'b1};
          state_s = ST_DRIVE;
        end
      end
      ST_CHECK: begin
        // Early exit on first asymmetric pair; alpha=0 always walks every index
        if (mism_s) begin
          sym_s      = 1'b0;
          tt_valid_s = 1'b1;
          state_s    = ST_DONE;
        end else if (chk_r == LAST_IDX) begin
          sym_s      = 1'b1;
          tt_valid_s = 1'b1;
          state_s    = ST_DONE;
        end else begin
          chk_s = chk_r + {{(N_IN-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    done_s = (state_s == ST_DONE);
    busy_s = (state_s != ST_IDLE);
    if ((state_s == ST_DRIVE) || (state_s == ST_SAMPLE)) begin
      dut_x_s = idx_s;
    end else begin
      dut_x_s = {N_IN{1'b0}};
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= {N_IN{1'b0}};
      chk_r      <= {N_IN{1'b0}};
      alpha_r    <= {N_IN{1'b0}};
      settle_r   <= 4'd0;
      tt_r       <= {N_PTS{1'b0}};
      sym_r      <= 1'b0;
      tt_valid_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      dut_x_r    <= {N_IN{1'b0}};
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      chk_r      <= chk_s;
      alpha_r    <= alpha_s;
      settle_r   <= settle_s;
      tt_r       <= tt_s;
      sym_r      <= sym_s;
      tt_valid_r <= tt_valid_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
      dut_x_r    <= dut_x_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign dut_x    = dut_x_r;
  assign tt       = tt_r;
  assign tt_valid = tt_valid_r;
  assign sym      = sym_r;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Table-driven bench for tt_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3)
// share a table-based FUT; expected results go through a scoreboard queue.
module tb_tt_sweep_ctrl;

  typedef struct {
    bit          s3;
    logic [4:0]  alpha;
    logic [31:0] fut;
    logic [31:0] exp_tt;
    bit          exp_sym;
    int          exp_cyc;
    int          pa;
    logic [4:0]  pa_alpha;
    int          pb;
    logic [4:0]  pb_alpha;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [4:0]  alpha = 5'd0;
  logic [31:0] fut_tt = 32'd0;

  logic        busy1, done1, ttv1, sym1, busy3, done3, ttv3, sym3;
  logic [4:0]  dut_x1, dut_x3;
  logic [31:0] tt1, tt3;
  logic        dut_y1, dut_y3, start1, start3;

  logic        busy_m, done_m, ttv_m, sym_m;
  logic [4:0]  dut_x_m;
  logic [31:0] tt_m;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t sb_q[$];
  vec_t vecs[11];

  always #5 clk = ~clk;

  assign dut_y1 = fut_tt[dut_x1];
  assign dut_y3 = fut_tt[dut_x3];
  assign start1 = start & ~sel;
  assign start3 = start & sel;

  assign busy_m  = sel ? busy3  : busy1;
  assign done_m  = sel ? done3  : done1;
  assign ttv_m   = sel ? ttv3   : ttv1;
  assign sym_m   = sel ? sym3   : sym1;
  assign dut_x_m = sel ? dut_x3 : dut_x1;
  assign tt_m    = sel ? tt3    : tt1;

  tt_sweep_ctrl #(.N_IN(5), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .alpha(alpha),
    .busy(busy1), .done(done1), .dut_x(dut_x1), .dut_y(dut_y1),
    .tt(tt1), .tt_valid(ttv1), .sym(sym1)
  );

  tt_sweep_ctrl #(.N_IN(5), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .alpha(alpha),
    .busy(busy3), .done(done3), .dut_x(dut_x3), .dut_y(dut_y3),
    .tt(tt3), .tt_valid(ttv3), .sym(sym3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: symmetry by brute force, done cycle from sweep length + checks used
  task automatic model(input logic [31:0] f, input logic [4:0] a, input int hold,
                       output bit s, output int cyc);
    int nchk;
    logic [4:0] j;
    s = 1'b1;
    nchk = 32;
    for (int i = 31; i >= 0; i--) begin
      j = 5'(i) ^ a;
      if (f[i] != f[j]) begin
        s = 1'b0;
        nchk = i + 1;
      end
    end
    cyc = 1 + 32 * hold + nchk;
  endtask

  function automatic vec_t mk(input bit s3, input logic [4:0] a, input logic [31:0] f,
                              input logic [31:0] ett, input bit es, input int ec);
    vec_t v;
    v.s3 = s3; v.alpha = a; v.fut = f; v.exp_tt = ett; v.exp_sym = es; v.exp_cyc = ec;
    v.pa = -1; v.pa_alpha = 5'd0; v.pb = -1; v.pb_alpha = 5'd0;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  {31'd0, busy_m}, 32'd0);
    check({tag, "_done"},  {31'd0, done_m}, 32'd0);
    check({tag, "_dut_x"}, {27'd0, dut_x_m}, 32'd0);
    check({tag, "_tt"},    tt_m, 32'd0);
    check({tag, "_ttv"},   {31'd0, ttv_m}, 32'd0);
    check({tag, "_sym"},   {31'd0, sym_m}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   cyc;
    int   hold;
    int   xerr;
    int   exp_x;
    bit   got_done;
    vec_t e;
    sel = v.s3;
    fut_tt = v.fut;
    hold = v.s3 ? 4 : 2;
    sb_q.push_back(v);
    @(negedge clk);
    alpha = v.alpha;
    start = 1'b1;
    cyc = 0;
    xerr = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      alpha = v.alpha;
      if (cyc == 1) begin
        check($sformatf("v%0d_start_busy", id), {31'd0, busy_m}, 32'd1);
        check($sformatf("v%0d_start_ttv_clr", id), {31'd0, ttv_m}, 32'd0);
      end
      exp_x = (cyc <= 32 * hold) ? (cyc - 1) / hold : 0;
      if (dut_x_m !== 5'(exp_x)) xerr++;
      if (done_m === 1'b1) got_done = 1'b1;
      if (cyc == v.pa) begin start = 1'b1; alpha = v.pa_alpha; end
      if (cyc == v.pb) begin start = 1'b1; alpha = v.pb_alpha; end
    end
    e = sb_q.pop_front();
    if (!got_done) begin
      check($sformatf("v%0d_done_timeout", id), 32'd0, 32'd1);
    end else begin
      check($sformatf("v%0d_done_cycle", id), cyc, e.exp_cyc);
      check($sformatf("v%0d_tt", id), tt_m, e.exp_tt);
      check($sformatf("v%0d_sym", id), {31'd0, sym_m}, {31'd0, e.exp_sym});
      check($sformatf("v%0d_ttv_at_done", id), {31'd0, ttv_m}, 32'd1);
    end
    check($sformatf("v%0d_dut_x_seq", id), xerr, 32'd0);
    @(negedge clk);
    start = 1'b0;
    alpha = v.alpha;
    check($sformatf("v%0d_done_pulse", id), {31'd0, done_m}, 32'd0);
    check($sformatf("v%0d_idle_busy", id), {31'd0, busy_m}, 32'd0);
    check($sformatf("v%0d_ttv_hold", id), {31'd0, ttv_m}, 32'd1);
    check($sformatf("v%0d_sym_hold", id), {31'd0, sym_m}, {31'd0, e.exp_sym});
  endtask

  initial begin
    bit          s;
    int          c;
    bit          saw_done;
    logic [31:0] f;
    logic [4:0]  a;
    logic [4:0]  j;

    vecs[0] = mk(1'b0, 5'b00010, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b1, 97);
    vecs[1] = mk(1'b0, 5'b00001, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 66);
    vecs[2] = mk(1'b0, 5'b00000, 32'h00000000, 32'h00000000, 1'b1, 97);
    vecs[3] = mk(1'b1, 5'b00111, 32'hFF000000, 32'hFF000000, 1'b1, 161);
    vecs[4] = mk(1'b0, 5'b00010, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b1, 97);
    vecs[4].pa = 5;  vecs[4].pa_alpha = 5'b00001;
    vecs[4].pb = 70; vecs[4].pb_alpha = 5'b00011;
    vecs[5] = mk(1'b0, 5'b00010, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b1, 97);
    vecs[5].pb = 97; vecs[5].pb_alpha = 5'b00001;
    vecs[6] = mk(1'b1, 5'b10000, 32'hFF000000, 32'hFF000000, 1'b0, 138);
    for (int k = 7; k < 11; k++) begin
      a = 5'($urandom_range(1, 31));
      f = $urandom;
      if (k < 9) begin
        for (int i = 0; i < 32; i++) begin
          j = 5'(i) ^ a;
          if (int'(j) < i) f[i] = f[j];
        end
      end
      model(f, a, (k % 2 == 1) ? 4 : 2, s, c);
      vecs[k] = mk(k % 2 == 1, a, f, f, s, c);
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    sel = 1'b0;
    check_reset_outputs("por1");
    sel = 1'b1;
    check_reset_outputs("por3");

    for (int k = 0; k < 11; k++) run_vec(vecs[k], k);

    // Abort a sweep with reset at cycle 20, then confirm silence and recovery
    sel = 1'b0;
    fut_tt = 32'hAAAAAAAA;
    @(negedge clk);
    alpha = 5'b00010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("abort_busy_before", {31'd0, busy_m}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("abort");
    saw_done = 1'b0;
    repeat (120) begin
      @(negedge clk);
      if (done_m === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    run_vec(vecs[0], 11);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
